// File: rtl/serial_mag_comp_if.sv
// Bus bundle for serial_mag_comp: nibble load/control strobes from the
// switch/button side and the compare status toward the LED drivers.
interface serial_mag_comp_if;
  logic [3:0] y;
  logic       ld_a;
  logic       ld_b;
  logic       clr;
  logic       start;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;

  modport master (
    output y, ld_a, ld_b, clr, start,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  y, ld_a, ld_b, clr, start,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: nibble-loaded operands A and B, compared bit-serially
// MSB first; stops at the first differing bit and pulses done for one cycle.
// Optional feature macro: SIGNED_CMP_EN (two's complement compare).
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  serial_mag_comp_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int PW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int IW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [PW-1:0]    ptr_a;
  logic [PW-1:0]    ptr_b;
  logic [IW-1:0]    idx;

  logic bit_a;
  logic bit_b;
  logic diff;
  logic a_wins;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(NIB - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decide the current bit: does it differ, and if so is A the larger one.
  always_comb begin
    bit_a = a[idx];
    bit_b = b[idx];
    diff  = bit_a ^ bit_b;
`ifdef SIGNED_CMP_EN
    // On the sign bit the operand holding a 1 is the negative (smaller) one.
    a_wins = (idx == IW'(WIDTH - 1)) ? bit_b : bit_a;
`else
    a_wins = bit_a;
`endif
  end

  // Control FSM with operand loading and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      ptr_a    <= '0;
      ptr_b    <= '0;
      idx      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.gt   <= 1'b0;
      bus.eq   <= 1'b1;
      bus.lt   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            // start takes priority; loads and clr in this cycle are dropped
            state    <= CMP;
            idx      <= IW'(WIDTH - 1);
            bus.busy <= 1'b1;
          end else begin
            if (bus.ld_a) begin
              a[{ptr_a, 2'b00} +: 4] <= bus.y;
              ptr_a                  <= next_ptr(ptr_a);
            end
            if (bus.ld_b) begin
              b[{ptr_b, 2'b00} +: 4] <= bus.y;
              ptr_b                  <= next_ptr(ptr_b);
            end
            // clr overrides the pointer advance but not the nibble write
            if (bus.clr) begin
              ptr_a <= '0;
              ptr_b <= '0;
            end
          end
        end
        CMP: begin
          if (diff || (idx == '0)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.gt   <= diff & a_wins;
            bus.lt   <= diff & ~a_wins;
            bus.eq   <= ~diff;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Testbench for serial_mag_comp: directed table, corner sequences and a
// randomized run against a behavioural model (WIDTH=8), plus WIDTH=16 checks.
module tb_serial_mag_comp;

  logic clk = 1'b0;
  logic reset = 1'b1;

  serial_mag_comp_if bus8();
  serial_mag_comp_if bus16();

  serial_mag_comp #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
  serial_mag_comp #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model of the 8-bit operand registers and load pointers
  logic [7:0] a_m, b_m;
  int pa, pb;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         k;
    logic       gt;
    logic       eq;
    logic       lt;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected outcome from plain arithmetic on the operand values
  task automatic model_exp(input logic [7:0] a, input logic [7:0] b,
                           output int k, output logic egt, output logic eeq, output logic elt);
    logic [7:0] x;
    x = a ^ b;
    k = 8;
    for (int i = 7; i >= 0; i--) begin
      if (x[i]) begin
        k = 8 - i;
        break;
      end
    end
`ifdef SIGNED_CMP_EN
    egt = $signed(a) > $signed(b);
    elt = $signed(a) < $signed(b);
`else
    egt = a > b;
    elt = a < b;
`endif
    eeq = (a == b);
  endtask

  task automatic load(input logic la, input logic lb, input logic [3:0] yv, input logic c);
    bus8.y = yv; bus8.ld_a = la; bus8.ld_b = lb; bus8.clr = c;
    tick();
    bus8.ld_a = 1'b0; bus8.ld_b = 1'b0; bus8.clr = 1'b0;
    if (la) begin a_m[pa*4 +: 4] = yv; pa = (pa + 1) % 2; end
    if (lb) begin b_m[pb*4 +: 4] = yv; pb = (pb + 1) % 2; end
    if (c) begin pa = 0; pb = 0; end
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
    load(1'b0, 1'b0, 4'h0, 1'b1);
    load(1'b1, 1'b0, a[3:0], 1'b0);
    load(1'b0, 1'b1, b[3:0], 1'b0);
    load(1'b1, 1'b0, a[7:4], 1'b0);
    load(1'b0, 1'b1, b[7:4], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_m = '0; b_m = '0; pa = 0; pb = 0;
  endtask

  // start a compare (optionally with an ld_a that must be dropped) and check it
  task automatic run8(input string nm, input int ek, input logic egt, input logic eeq,
                      input logic elt, input logic with_ld, input logic [3:0] ldy);
    int cyc, busy_n;
    logic [2:0] prev;
    prev = {bus8.gt, bus8.eq, bus8.lt};
    bus8.start = 1'b1; bus8.ld_a = with_ld; bus8.y = ldy;
    tick();
    bus8.start = 1'b0; bus8.ld_a = 1'b0;
    cyc = 1; busy_n = 0;
    check({nm, "_hold"}, {29'd0, bus8.gt, bus8.eq, bus8.lt}, {29'd0, prev});
    while (!bus8.done && cyc <= 12) begin
      if (bus8.busy) busy_n++;
      tick();
      cyc++;
    end
    check({nm, "_done"}, bus8.done, 1);
    check({nm, "_lat"}, cyc, ek + 1);
    check({nm, "_busy"}, busy_n, ek);
    check({nm, "_res"}, {bus8.gt, bus8.eq, bus8.lt}, {egt, eeq, elt});
    tick();
    check({nm, "_pulse"}, {bus8.done, bus8.busy}, 2'b00);
  endtask

  task automatic load16(input logic la, input logic lb, input logic [3:0] yv, input logic c);
    bus16.y = yv; bus16.ld_a = la; bus16.ld_b = lb; bus16.clr = c;
    tick();
    bus16.ld_a = 1'b0; bus16.ld_b = 1'b0; bus16.clr = 1'b0;
  endtask

  task automatic run16(input string nm, input int ek, input logic egt, input logic eeq, input logic elt);
    int cyc;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    cyc = 1;
    while (!bus16.done && cyc <= 20) begin
      tick();
      cyc++;
    end
    check({nm, "_done"}, bus16.done, 1);
    check({nm, "_lat"}, cyc, ek + 1);
    check({nm, "_res"}, {bus16.gt, bus16.eq, bus16.lt}, {egt, eeq, elt});
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ek, nd;
    logic egt, eeq, elt;
    logic [7:0] ra, rb;

    bus8.y = '0; bus8.ld_a = 0; bus8.ld_b = 0; bus8.clr = 0; bus8.start = 0;
    bus16.y = '0; bus16.ld_a = 0; bus16.ld_b = 0; bus16.clr = 0; bus16.start = 0;

    // {A, B, k, gt, eq, lt}
    vecs.push_back('{8'h3C, 8'h3A, 6, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 8, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h12, 8'h13, 8, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'hFF, 8'hFE, 8, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hA5, 8'hA5, 8, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h40, 8'h20, 2, 1'b1, 1'b0, 1'b0});
`ifdef SIGNED_CMP_EN
    vecs.push_back('{8'h80, 8'h7F, 1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h55, 8'hAA, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h7F, 8'h80, 1, 1'b1, 1'b0, 1'b0});
`else
    vecs.push_back('{8'h80, 8'h7F, 1, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, 8'hAA, 1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 8'h80, 1, 1'b0, 1'b0, 1'b1});
`endif

    // reset state
    tick();
    do_reset();
    check("rst8_out", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 5'b00010);
    check("rst16_out", {bus16.busy, bus16.done, bus16.gt, bus16.eq, bus16.lt}, 5'b00010);

    // compare straight out of reset: A = B = 0
    run8("rst_cmp", 8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    // directed table
    foreach (vecs[i]) begin
      set_ops(vecs[i].a, vecs[i].b);
      run8($sformatf("vec%0d", i), vecs[i].k, vecs[i].gt, vecs[i].eq, vecs[i].lt, 1'b0, 4'h0);
    end

    // pointer wrap, clr, and clr together with a load
    do_reset();
    load(1'b1, 1'b0, 4'h1, 1'b0);
    load(1'b1, 1'b0, 4'h2, 1'b0);
    load(1'b1, 1'b0, 4'h5, 1'b0);
    load(1'b0, 1'b1, 4'h5, 1'b0);
    load(1'b0, 1'b1, 4'h2, 1'b0);
    check("wrap_model", a_m, 8'h25);
    run8("wrap", 8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    load(1'b0, 1'b0, 4'h0, 1'b1);
    load(1'b1, 1'b0, 4'h7, 1'b0);
    run8("clr_ld", 7, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    load(1'b1, 1'b0, 4'h9, 1'b1);
    load(1'b1, 1'b0, 4'h4, 1'b0);
    check("clr_same_model", a_m, 8'h94);
`ifdef SIGNED_CMP_EN
    run8("clr_same", 1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    run8("start_ld", 1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2);
`else
    run8("clr_same", 1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    run8("start_ld", 1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h2);
`endif

    // simultaneous ld_a and ld_b share y
    load(1'b0, 1'b0, 4'h0, 1'b1);
    load(1'b1, 1'b1, 4'h4, 1'b0);
    load(1'b1, 1'b1, 4'h6, 1'b0);
    run8("both_ld", 8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    // start and ld_a during CMP are ignored; exactly one done
    set_ops(8'h3C, 8'h3C);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    bus8.start = 1'b1; bus8.ld_a = 1'b1; bus8.y = 4'hF;
    tick();
    bus8.start = 1'b0; bus8.ld_a = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus8.done) nd++;
      tick();
    end
    check("cmp_ignore_done", nd, 1);
    check("cmp_ignore_eq", bus8.eq, 1);
    run8("cmp_ignore_a", 8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);

    // reset during the fourth CMP cycle aborts without a done pulse
    set_ops(8'h3C, 8'h3A);
    run8("pre_abort", 6, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before", bus8.busy, 1);
    do_reset();
    check("abort_out", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, 5'b00010);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) nd++;
      tick();
    end
    check("abort_nodone", nd, 0);

    // randomized operands against the behavioural model
    for (int t = 0; t < 40; t++) begin
      ra = 8'($urandom);
      case ($urandom_range(2, 0))
        0: rb = 8'($urandom);
        1: rb = ra;
        default: rb = ra ^ (8'h01 << $urandom_range(7, 0));
      endcase
      set_ops(ra, rb);
      model_exp(a_m, b_m, ek, egt, eeq, elt);
      run8($sformatf("rnd%0d", t), ek, egt, eeq, elt, 1'b0, 4'h0);
    end

    // WIDTH = 16
    load16(1'b0, 1'b0, 4'h0, 1'b1);
    load16(1'b1, 1'b1, 4'h4, 1'b0);
    load16(1'b1, 1'b1, 4'h3, 1'b0);
    load16(1'b1, 1'b1, 4'h2, 1'b0);
    load16(1'b1, 1'b1, 4'h1, 1'b0);
    run16("w16_eq", 16, 1'b0, 1'b1, 1'b0);
    load16(1'b0, 1'b0, 4'h0, 1'b1);
    load16(1'b1, 1'b0, 4'h4, 1'b0);
    load16(1'b1, 1'b0, 4'h3, 1'b0);
    load16(1'b1, 1'b0, 4'h2, 1'b0);
    load16(1'b1, 1'b0, 4'h9, 1'b0);
`ifdef SIGNED_CMP_EN
    run16("w16_msb", 1, 1'b0, 1'b0, 1'b1);
`else
    run16("w16_msb", 1, 1'b1, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
